// File: rtl/soc_periph_evt_tx.sv
// soc_periph_evt_tx: coalesces SoC peripheral event pulses into a round-robin arbitrated FIFO of event IDs over valid/ready
module soc_periph_evt_tx #(
  parameter int NB_SOURCES  = 32,
  parameter int EVNT_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int SOURCE_BASE = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NB_SOURCES-1:0]              evt_i,
  output logic                               evt_valid_o,
  input  logic                               evt_ready_i,
  output logic [EVNT_WIDTH-1:0]              evt_data_o,
  output logic                               lost_o,
  output logic [EVNT_WIDTH-1:0]              lost_id_o,
  output logic [7:0]                         lost_cnt_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o,
  output logic                               busy_o
);
  localparam int RW = NB_SOURCES > 1 ? $clog2(NB_SOURCES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [RW:0] NBL = (RW+1)'(NB_SOURCES);
  if (longint'(SOURCE_BASE) + longint'(NB_SOURCES) - 1 >= (longint'(1) << EVNT_WIDTH)) begin : g_bad_base
    $error("SOURCE_BASE+NB_SOURCES-1 does not fit in EVNT_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  logic [NB_SOURCES-1:0] pend, grant, loss;
  logic [RW-1:0]         rr, rr_nxt, gk, j;
  logic [RW:0]           s, nx;
  logic                  push, pop, full;
  logic [EVNT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [EVNT_WIDTH-1:0] lid, din;
  logic [AW-1:0]         wptr, rptr;
  logic [LW-1:0]         cnt;
  assign full         = cnt == LW'(FIFO_DEPTH);
  assign evt_valid_o  = cnt != '0;
  assign evt_data_o   = evt_valid_o ? mem[rptr] : '0;
  assign fifo_level_o = cnt;
  assign busy_o       = |pend || evt_valid_o;
  assign pop          = evt_valid_o && evt_ready_i;
  assign loss         = evt_i & pend & ~grant;
  assign din          = EVNT_WIDTH'(SOURCE_BASE + int'(gk));
  assign nx           = {1'b0, gk} + 1'b1;
  assign rr_nxt       = nx == NBL ? '0 : nx[RW-1:0];
  always_comb begin
    grant = '0;
    gk    = '0;
    push  = 1'b0;
    s     = '0;
    j     = '0;
    for (int i = 0; i < NB_SOURCES; i++) begin
      s = {1'b0, rr} + (RW+1)'(i);
      j = s >= NBL ? RW'(s - NBL) : RW'(s);
      if (!full && !push && pend[j]) begin
        grant[j] = 1'b1;
        gk       = j;
        push     = 1'b1;
      end
    end
  end
  always_comb begin
    lid = '0;
    for (int k = NB_SOURCES - 1; k >= 0; k--)
      if (loss[k]) lid = EVNT_WIDTH'(SOURCE_BASE + k);
  end
  always_ff @(posedge clk_i)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend       <= '0;
      rr         <= '0;
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      lost_o     <= 1'b0;
      lost_id_o  <= '0;
      lost_cnt_o <= '0;
    end else begin
      pend      <= (pend & ~grant) | evt_i;
      lost_o    <= |loss;
      lost_id_o <= lid;
      cnt       <= cnt + LW'(push) - LW'(pop);
      if (push) wptr <= wptr + 1'b1;
      if (push) rr <= rr_nxt;
      if (pop) rptr <= rptr + 1'b1;
      if (|loss && lost_cnt_o != 8'hff) lost_cnt_o <= lost_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_soc_periph_evt_tx.sv
// tb_soc_periph_evt_tx: directed checks of arbitration order, backpressure, coalescing, saturation and reset
module tb_soc_periph_evt_tx;
  localparam int NB   = 32;
  localparam int BASE = 'h20;
  logic        clk = 1'b0;
  logic        rst_i, evt_valid_o, evt_ready_i, lost_o, busy_o;
  logic [NB-1:0] evt_i;
  logic [7:0]  evt_data_o, lost_id_o, lost_cnt_o;
  logic [3:0]  fifo_level_o;
  int          vectors = 0, miscompares = 0;
  logic [7:0]  got [$];
  int          exp_q [$];
  always #5 clk = ~clk;
  soc_periph_evt_tx #(.NB_SOURCES(NB), .EVNT_WIDTH(8), .FIFO_DEPTH(8), .SOURCE_BASE(BASE)) dut (
    .clk_i(clk), .rst_i(rst_i), .evt_i(evt_i), .evt_valid_o(evt_valid_o), .evt_ready_i(evt_ready_i),
    .evt_data_o(evt_data_o), .lost_o(lost_o), .lost_id_o(lost_id_o), .lost_cnt_o(lost_cnt_o),
    .fifo_level_o(fifo_level_o), .busy_o(busy_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, evt_valid_o, 0);
    chk({tag, "_data"}, evt_data_o, 0);
    chk({tag, "_lost"}, lost_o, 0);
    chk({tag, "_lost_id"}, lost_id_o, 0);
    chk({tag, "_lost_cnt"}, lost_cnt_o, 0);
    chk({tag, "_level"}, fifo_level_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask
  task automatic collect(input int n);
    int cyc = 0;
    while (got.size() < n && cyc < 300) begin
      if (evt_valid_o && evt_ready_i) got.push_back(evt_data_o);
      tick;
      cyc++;
    end
  endtask
  task automatic check_got(input string tag);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), i < got.size() ? 32'(got[i]) : 32'hdead, 32'(BASE + exp_q[i]));
  endtask
  task automatic burst(input logic [NB-1:0] m, input int n, input string tag);
    evt_i = m;
    tick;
    evt_i = '0;
    got.delete();
    collect(n);
    check_got(tag);
  endtask
  initial begin
    rst_i = 1'b1;
    evt_i = '0;
    evt_ready_i = 1'b0;
    tick;
    tick;
    chk_idle("reset");
    rst_i = 1'b0;
    evt_ready_i = 1'b1;
    evt_i = 32'h1 << 5;
    tick;
    evt_i = '0;
    chk("single_n1_valid", evt_valid_o, 0);
    chk("single_n1_busy", busy_o, 1);
    tick;
    chk("single_n2_valid", evt_valid_o, 1);
    chk("single_n2_data", evt_data_o, BASE + 5);
    tick;
    chk("single_n3_valid", evt_valid_o, 0);
    chk("single_n3_busy", busy_o, 0);
    do_reset;
    exp_q = '{1, 3, 7};
    burst((32'h1 << 1) | (32'h1 << 3) | (32'h1 << 7), 3, "rr_a");
    exp_q = '{9, 1};
    burst((32'h1 << 1) | (32'h1 << 9), 2, "rr_b");
    exp_q = '{3, 1};
    burst((32'h1 << 1) | (32'h1 << 3), 2, "rr_c");
    do_reset;
    evt_ready_i = 1'b0;
    evt_i = 32'hfff;
    tick;
    evt_i = '0;
    repeat (12) tick;
    chk("bp_level", fifo_level_o, 8);
    chk("bp_valid", evt_valid_o, 1);
    chk("bp_data", evt_data_o, BASE);
    chk("bp_busy", busy_o, 1);
    chk("bp_lost", lost_o, 0);
    evt_ready_i = 1'b1;
    got.delete();
    got.push_back(evt_data_o);
    tick;
    chk("bp_nobypass_level", fifo_level_o, 7);
    collect(12);
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back(i);
    check_got("bp_order");
    chk("bp_lost_cnt", lost_cnt_o, 0);
    do_reset;
    evt_ready_i = 1'b0;
    evt_i = 32'hff;
    tick;
    evt_i = '0;
    repeat (10) tick;
    chk("co_full", fifo_level_o, 8);
    evt_i = (32'h1 << 4) | (32'h1 << 6);
    tick;
    evt_i = '0;
    chk("co_first_lost", lost_o, 0);
    repeat (2) tick;
    evt_i = (32'h1 << 4) | (32'h1 << 6);
    tick;
    evt_i = '0;
    chk("co_lost", lost_o, 1);
    chk("co_lost_id", lost_id_o, BASE + 4);
    chk("co_lost_cnt", lost_cnt_o, 1);
    tick;
    chk("co_lost_pulse", lost_o, 0);
    chk("co_lost_cnt_hold", lost_cnt_o, 1);
    evt_i = 32'h1 << 6;
    tick;
    evt_i = '0;
    chk("co_lost6", lost_o, 1);
    chk("co_lost_id6", lost_id_o, BASE + 6);
    chk("co_lost_cnt2", lost_cnt_o, 2);
    evt_i = 32'h1 << 4;
    repeat (260) tick;
    evt_i = '0;
    tick;
    chk("co_sat", lost_cnt_o, 255);
    chk("co_sat_lost", lost_o, 0);
    evt_ready_i = 1'b1;
    got.delete();
    collect(10);
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 4, 6};
    check_got("co_drain");
    repeat (2) tick;
    chk("co_empty_valid", evt_valid_o, 0);
    chk("co_empty_busy", busy_o, 0);
    do_reset;
    evt_i = 32'h1 << 2;
    tick;
    evt_i = 32'h1 << 2;
    tick;
    evt_i = '0;
    chk("rp_lost", lost_o, 0);
    got.delete();
    if (evt_valid_o) got.push_back(evt_data_o);
    tick;
    collect(2);
    exp_q = '{2, 2};
    check_got("rp_ids");
    chk("rp_lost_cnt", lost_cnt_o, 0);
    evt_ready_i = 1'b0;
    evt_i = 32'h1f;
    tick;
    evt_i = '0;
    repeat (6) tick;
    chk("rm_level", fifo_level_o, 5);
    rst_i = 1'b1;
    evt_i = '1;
    tick;
    rst_i = 1'b0;
    evt_i = '0;
    chk_idle("rm");
    evt_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rm_stale_valid", evt_valid_o, 0);
    end
    chk("rm_busy", busy_o, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
